// File: rtl/axi_reg_arb.sv
// rtl/axi_reg_arb.sv - two-requester arbiter onto an AXI-Lite register slave
// One transaction outstanding at a time; a watchdog bounds every bus transaction.
module axi_reg_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    areset,
    input  logic [1:0]              req_valid_i,
    input  logic [1:0]              req_write_i,
    input  logic [2*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [2*DATA_WIDTH-1:0] req_wdata_i,
    input  logic [7:0]              req_wstrb_i,
    output logic [1:0]              req_ready_o,
    output logic [1:0]              rsp_valid_o,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic [ADDR_WIDTH-1:0]   awaddr_o,
    output logic                    awvalid_o,
    input  logic                    awready_i,
    output logic [DATA_WIDTH-1:0]   wdata_o,
    output logic [3:0]              wstrb_o,
    output logic                    wvalid_o,
    input  logic                    wready_i,
    input  logic [1:0]              bresp_i,
    input  logic                    bvalid_i,
    output logic                    bready_o,
    output logic [ADDR_WIDTH-1:0]   araddr_o,
    output logic                    arvalid_o,
    input  logic                    arready_i,
    input  logic [DATA_WIDTH-1:0]   rdata_i,
    input  logic                    rvalid_i,
    output logic                    rready_o
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA} state_t;

    state_t                  state_q;
    logic                    last_grant_q;
    logic [WD_W-1:0]         wd_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [3:0]              wstrb_q;
    logic [1:0]              req_ready_q;
    logic [1:0]              rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_err_q;
    logic                    awvalid_q;
    logic                    wvalid_q;
    logic                    bready_q;
    logic                    arvalid_q;
    logic                    rready_q;

    logic                    grant_d;
    logic [ADDR_WIDTH-1:0]   sel_addr_d;
    logic [DATA_WIDTH-1:0]   sel_wdata_d;
    logic [3:0]              sel_wstrb_d;
    logic                    sel_write_d;
    logic                    aw_done_d;
    logic                    w_done_d;
    logic [1:0]              rsp_onehot_d;
    logic                    timeout_d;

    always_comb begin
        // On a tie the requester that did not win last time gets the bus.
        grant_d      = (&req_valid_i) ? ~last_grant_q : req_valid_i[1];
        sel_addr_d   = grant_d ? req_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr_i[ADDR_WIDTH-1:0];
        sel_wdata_d  = grant_d ? req_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata_i[DATA_WIDTH-1:0];
        sel_wstrb_d  = grant_d ? req_wstrb_i[7:4] : req_wstrb_i[3:0];
        sel_write_d  = grant_d ? req_write_i[1] : req_write_i[0];
        aw_done_d    = !awvalid_q || awready_i;
        w_done_d     = !wvalid_q || wready_i;
        rsp_onehot_d = last_grant_q ? 2'b10 : 2'b01;
        timeout_d    = (state_q != IDLE) && (wd_q == WD_W'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            wd_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            req_ready_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
        end else begin
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            if (state_q != IDLE) begin
                wd_q <= wd_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (|req_valid_i) begin
                        last_grant_q <= grant_d;
                        req_ready_q  <= grant_d ? 2'b10 : 2'b01;
                        wd_q         <= '0;
                        addr_q       <= sel_addr_d;
                        wdata_q      <= sel_wdata_d;
                        wstrb_q      <= sel_wstrb_d;
                        if (sel_write_d) begin
                            state_q   <= WR_ADDR;
                            awvalid_q <= (sel_addr_d < ADDR_WIDTH'(8));
                            wvalid_q  <= (sel_addr_d < ADDR_WIDTH'(8));
                        end else begin
                            state_q   <= RD_ADDR;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                WR_ADDR: begin
                    if (addr_q >= ADDR_WIDTH'(8)) begin
                        rsp_valid_q <= rsp_onehot_d;
                        rsp_err_q   <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        if (awready_i) awvalid_q <= 1'b0;
                        if (wready_i)  wvalid_q  <= 1'b0;
                        if (aw_done_d && w_done_d) begin
                            bready_q <= 1'b1;
                            state_q  <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (bvalid_i) begin
                        bready_q    <= 1'b0;
                        rsp_valid_q <= rsp_onehot_d;
                        rsp_err_q   <= (bresp_i != 2'b00);
                        state_q     <= IDLE;
                    end
                end
                RD_ADDR: begin
                    if (arready_i) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rvalid_i) begin
                        rready_q    <= 1'b0;
                        rsp_rdata_q <= rdata_i;
                        rsp_valid_q <= rsp_onehot_d;
                        rsp_err_q   <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // Watchdog expiry overrides whatever the bus did this cycle.
            if (timeout_d) begin
                awvalid_q   <= 1'b0;
                wvalid_q    <= 1'b0;
                bready_q    <= 1'b0;
                arvalid_q   <= 1'b0;
                rready_q    <= 1'b0;
                rsp_valid_q <= rsp_onehot_d;
                rsp_err_q   <= 1'b1;
                state_q     <= IDLE;
            end
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign awaddr_o    = addr_q;
    assign araddr_o    = addr_q;
    assign awvalid_o   = awvalid_q;
    assign wdata_o     = wdata_q;
    assign wstrb_o     = wstrb_q;
    assign wvalid_o    = wvalid_q;
    assign bready_o    = bready_q;
    assign arvalid_o   = arvalid_q;
    assign rready_o    = rready_q;

endmodule

// File: tb/tb_axi_reg_arb.sv
// tb/tb_axi_reg_arb.sv - directed bench for axi_reg_arb
// Behavioural register slave: 8 words, any address >= 8 reads back the XOR of all words.
module tb_axi_reg_arb;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          areset = 1'b0;
    logic [1:0]    req_valid_i, req_write_i;
    logic [2*AW-1:0] req_addr_i;
    logic [2*DW-1:0] req_wdata_i;
    logic [7:0]    req_wstrb_i;
    logic [1:0]    req_ready_o, rsp_valid_o;
    logic [DW-1:0] rsp_rdata_o;
    logic          rsp_err_o;
    logic [AW-1:0] awaddr_o, araddr_o;
    logic          awvalid_o, awready_i, wvalid_o, wready_i;
    logic [DW-1:0] wdata_o, rdata_i;
    logic [3:0]    wstrb_o;
    logic [1:0]    bresp_i;
    logic          bvalid_i, bready_o, arvalid_o, arready_i, rvalid_i, rready_o;

    logic          b_en, b_err;
    logic          aw_got, w_got;
    logic [2:0]    aw_a;
    logic [DW-1:0] w_d;
    logic [3:0]    w_s;
    logic [DW-1:0] regs [8];
    logic [DW-1:0] crc;
    int            aw_hs = 0;
    int            aw_cyc = 0;
    int            w_cyc = 0;
    int            n_vec = 0;
    int            n_err = 0;

    axi_reg_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .areset(areset),
        .req_valid_i(req_valid_i), .req_write_i(req_write_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i), .req_ready_o(req_ready_o),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
        .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rdata_i(rdata_i), .rvalid_i(rvalid_i), .rready_o(rready_o)
    );

    always #5 clk = ~clk;

    always_comb begin
        crc = '0;
        for (int i = 0; i < 8; i++) crc = crc ^ regs[i];
    end

    always @(posedge clk or negedge areset) begin
        if (!areset) begin
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            bvalid_i <= 1'b0;
            bresp_i  <= 2'b00;
            rvalid_i <= 1'b0;
            rdata_i  <= '0;
        end else begin
            if (awvalid_o) aw_cyc <= aw_cyc + 1;
            if (wvalid_o)  w_cyc  <= w_cyc + 1;
            if (awvalid_o && awready_i) begin
                aw_got <= 1'b1;
                aw_a   <= awaddr_o[2:0];
                aw_hs  <= aw_hs + 1;
            end
            if (wvalid_o && wready_i) begin
                w_got <= 1'b1;
                w_d   <= wdata_o;
                w_s   <= wstrb_o;
            end
            if (aw_got && w_got && !bvalid_i && b_en) begin
                for (int b = 0; b < 4; b++)
                    if (w_s[b]) regs[aw_a][8*b +: 8] <= w_d[8*b +: 8];
                bvalid_i <= 1'b1;
                bresp_i  <= b_err ? 2'b10 : 2'b00;
                aw_got   <= 1'b0;
                w_got    <= 1'b0;
            end
            if (bvalid_i && bready_o) bvalid_i <= 1'b0;
            if (arvalid_o && arready_i) begin
                rvalid_i <= 1'b1;
                rdata_i  <= (araddr_o < 8) ? regs[araddr_o[2:0]] : crc;
            end
            if (rvalid_i && rready_o) rvalid_i <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait for its grant and its response; returns at the response cycle.
    task automatic do_req(input int n, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] rv, output logic err,
                          output logic [31:0] rd, output int lat);
        req_valid_i[n]          = 1'b1;
        req_write_i[n]          = wr;
        req_addr_i[n*AW +: AW]  = addr;
        req_wdata_i[n*DW +: DW] = data;
        req_wstrb_i[n*4 +: 4]   = strb;
        for (int c = 0; c < 40 && !req_ready_o[n]; c++) @(negedge clk);
        chk($sformatf("grant_req%0d", n), {63'd0, req_ready_o[n]}, 64'd1);
        req_valid_i[n] = 1'b0;
        lat = 0;
        for (int c = 0; c < TO + 40; c++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid_o != 2'b00) break;
        end
        rv  = rsp_valid_o;
        err = rsp_err_o;
        rd  = rsp_rdata_o;
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit observed=no_finish expected=finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  rv;
        logic        err;
        logic [31:0] rd;
        int          lat;
        int          base, base2;
        logic [1:0]  exp_g;

        req_valid_i = '0; req_write_i = '0; req_addr_i = '0;
        req_wdata_i = '0; req_wstrb_i = '0;
        awready_i = 1'b1; wready_i = 1'b1; arready_i = 1'b1;
        b_en = 1'b1; b_err = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_ctrl", {56'd0, req_ready_o, rsp_valid_o, awvalid_o, wvalid_o, bready_o, arvalid_o}, 64'd0);
        chk("rst_rready_err", {62'd0, rready_o, rsp_err_o}, 64'd0);
        chk("rst_rdata", rsp_rdata_o, 64'd0);
        chk("rst_addr_data", {awaddr_o, wdata_o}, 64'd0);
        areset = 1'b1;
        @(negedge clk);

        // Both requesters write continuously: grants must alternate, req0 first.
        req_write_i = 2'b11; req_addr_i = '0;
        req_wdata_i = {32'h0000_0022, 32'h0000_0011}; req_wstrb_i = 8'hFF;
        req_valid_i = 2'b11;
        for (int g = 0; g < 4; g++) begin
            exp_g = (g % 2 == 1) ? 2'b10 : 2'b01;
            for (int c = 0; c < 40 && req_ready_o == 2'b00; c++) @(negedge clk);
            chk($sformatf("alt_grant%0d", g), req_ready_o, exp_g);
            if (g == 3) req_valid_i = 2'b00;
            for (int c = 0; c < 40 && rsp_valid_o == 2'b00; c++) @(negedge clk);
            chk($sformatf("alt_rsp%0d", g), rsp_valid_o, exp_g);
            @(negedge clk);
        end

        base = aw_hs;
        do_req(0, 1'b1, 32'd3, 32'hA5A5_A5A5, 4'hF, rv, err, rd, lat);
        chk("wr3_rsp", {rv, err}, {2'b01, 1'b0});
        chk("wr3_one_aw", aw_hs - base, 64'd1);
        do_req(0, 1'b0, 32'd3, 32'd0, 4'h0, rv, err, rd, lat);
        chk("rd3_rsp", {rv, err}, {2'b01, 1'b0});
        chk("rd3_data", rd, 64'hA5A5_A5A5);

        b_err = 1'b1;
        do_req(1, 1'b1, 32'd4, 32'h0000_0099, 4'hF, rv, err, rd, lat);
        chk("bresp_err", {rv, err}, {2'b10, 1'b1});
        chk("rdata_hold", rd, 64'hA5A5_A5A5);
        b_err = 1'b0;

        base = aw_cyc; base2 = w_cyc;
        do_req(1, 1'b1, 32'd9, 32'h1234_5678, 4'hF, rv, err, rd, lat);
        chk("wr9_rsp", {rv, err}, {2'b10, 1'b1});
        chk("wr9_latency", lat, 64'd1);
        chk("wr9_no_bus", (aw_cyc - base) + (w_cyc - base2), 64'd0);

        for (int i = 0; i < 8; i++) begin
            do_req(0, 1'b1, i, (i < 3) ? (32'd1 << i) : 32'd0, 4'hF, rv, err, rd, lat);
            if (i == 2) chk("fill_wr2", {rv, err}, {2'b01, 1'b0});
        end
        do_req(1, 1'b0, 32'd8, 32'd0, 4'h0, rv, err, rd, lat);
        chk("crc_rsp", {rv, err}, {2'b10, 1'b0});
        chk("crc_data", rd, 64'h0000_0007);

        do_req(0, 1'b1, 32'd5, 32'hFFFF_FFFF, 4'b0101, rv, err, rd, lat);
        do_req(0, 1'b0, 32'd5, 32'd0, 4'h0, rv, err, rd, lat);
        chk("strb_data", rd, 64'h00FF_00FF);

        awready_i = 1'b0; wready_i = 1'b0;
        base = aw_hs;
        do_req(0, 1'b1, 32'd1, 32'h0000_DEAD, 4'hF, rv, err, rd, lat);
        chk("to_rsp", {rv, err}, {2'b01, 1'b1});
        chk("to_latency", lat, TO);
        chk("to_valids_drop", {62'd0, awvalid_o, wvalid_o}, 64'd0);
        chk("to_no_hs", aw_hs - base, 64'd0);
        awready_i = 1'b1; wready_i = 1'b1;
        do_req(1, 1'b0, 32'd1, 32'd0, 4'h0, rv, err, rd, lat);
        chk("post_to_rd", {rv, err, rd}, {2'b10, 1'b0, 32'h0000_0002});

        // Reset while waiting for the write response.
        b_en = 1'b0;
        req_valid_i[0] = 1'b1; req_write_i[0] = 1'b1;
        req_addr_i[AW-1:0] = 32'd6; req_wdata_i[DW-1:0] = 32'h0000_0077; req_wstrb_i[3:0] = 4'hF;
        for (int c = 0; c < 40 && !req_ready_o[0]; c++) @(negedge clk);
        req_valid_i[0] = 1'b0;
        for (int c = 0; c < 40 && !bready_o; c++) @(negedge clk);
        chk("wr_resp_bready", {63'd0, bready_o}, 64'd1);
        #2 areset = 1'b0;
        #1;
        chk("async_rst_ctrl", {58'd0, rsp_valid_o, req_ready_o, bready_o, awvalid_o}, 64'd0);
        chk("async_rst_addr", {awaddr_o, wdata_o}, 64'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rst_no_rsp%0d", c), {62'd0, rsp_valid_o}, 64'd0);
        end
        b_en = 1'b1;
        areset = 1'b1;
        @(negedge clk);
        do_req(0, 1'b1, 32'd6, 32'h0000_0123, 4'hF, rv, err, rd, lat);
        chk("post_rst_wr", {rv, err}, {2'b01, 1'b0});
        do_req(1, 1'b0, 32'd6, 32'd0, 4'h0, rv, err, rd, lat);
        chk("post_rst_rd", {rv, err, rd}, {2'b10, 1'b0, 32'h0000_0123});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
